// File: rtl/multdiv_unit.sv
// Iterative 32-bit signed multiply/divide: shift-add multiply, restoring divide.
// Fixed 34-cycle latency from start edge to the one-cycle ready pulse.
module multdiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_is_mult;
    logic               r_neg;
    logic               r_div0;
    // Multiplicand for MULT, divisor for DIV.
    logic [WIDTH-1:0]   r_opnd;
    // MULT: {partial product, multiplier}. DIV: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_result;
    logic               r_exc;

    logic               w_start;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_add;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quo_s;
    logic               w_mul_ovf;
    logic               w_div_exc;
    logic               w_unused;

    assign w_start = ctrl_MULT | ctrl_DIV;
    assign w_mag_a = data_operandA[WIDTH-1] ? ({WIDTH{1'b0}} - data_operandA) : data_operandA;
    assign w_mag_b = data_operandB[WIDTH-1] ? ({WIDTH{1'b0}} - data_operandB) : data_operandB;

    assign w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_add, r_acc[WIDTH-1:1]};

    assign w_shift    = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff     = {1'b0, w_shift} - {2'b00, r_opnd};
    // A borrow means the trial subtraction failed: keep the shifted remainder.
    assign w_div_next = w_diff[WIDTH+1]
                      ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                      : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_prod_s  = r_neg ? ({(2*WIDTH){1'b0}} - r_acc) : r_acc;
    assign w_mul_ovf = ~(&w_prod_s[2*WIDTH-1:WIDTH-1]) & (|w_prod_s[2*WIDTH-1:WIDTH-1]);
    assign w_quo_s   = r_neg ? ({WIDTH{1'b0}} - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    // A positive quotient with the MSB set only arises from MIN / -1.
    assign w_div_exc = r_div0 | (~r_neg & r_acc[WIDTH-1]);
    assign w_unused  = w_diff[WIDTH];

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_is_mult <= 1'b0;
            r_neg     <= 1'b0;
            r_div0    <= 1'b0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_result  <= '0;
            r_exc     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_is_mult <= ctrl_MULT;
                        r_neg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        r_div0    <= (data_operandB == '0);
                        r_opnd    <= ctrl_MULT ? w_mag_a : w_mag_b;
                        r_acc     <= {{WIDTH{1'b0}}, (ctrl_MULT ? w_mag_b : w_mag_a)};
                        r_cnt     <= '0;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    r_acc <= r_is_mult ? w_mul_next : w_div_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (r_is_mult) begin
                        r_result <= w_prod_s[WIDTH-1:0];
                        r_exc    <= w_mul_ovf;
                    end else begin
                        r_result <= r_div0 ? {WIDTH{1'b0}} : w_quo_s;
                        r_exc    <= w_div_exc;
                    end
                    r_state <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = (r_state == DONE);
    assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed-vector bench for multdiv_unit; outputs sampled on the falling edge.
module tb_multdiv_unit;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int vectors;
    int miscompares;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Start an op, scramble operands afterwards, and check latency and outputs.
    task automatic do_op(input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic exp_exc, input string nm);
        int k;
        @(negedge clock);
        ctrl_MULT = m;
        ctrl_DIV = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!data_resultRDY && k < 50);
        vectors++;
        if (k !== 34) begin
            miscompares++;
            $display("FAIL %s latency: got %0d cycles, want 34", nm, k);
        end
        vectors++;
        if (data_result !== exp_res) begin
            miscompares++;
            $display("FAIL %s result: got %08h, want %08h", nm, data_result, exp_res);
        end
        vectors++;
        if (data_exception !== exp_exc) begin
            miscompares++;
            $display("FAIL %s exception: got %b, want %b", nm, data_exception, exp_exc);
        end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_in_rdy: got %b, want 1", nm, busy);
        end
        @(negedge clock);
        vectors++;
        if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after_rdy: got rdy=%b busy=%b, want 0 0", nm, data_resultRDY, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = 32'h0;
        data_operandB = 32'h0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        vectors++;
        if ({data_result, data_exception, data_resultRDY, busy} !== 35'h0) begin
            miscompares++;
            $display("FAIL reset_state: got res=%08h exc=%b rdy=%b busy=%b, want all 0",
                     data_result, data_exception, data_resultRDY, busy);
        end
        reset = 1'b1;
    endtask

    task automatic test_mult();
        do_op(1'b1, 1'b0, 32'd6, 32'd7, 32'h0000002A, 1'b0, "mult_6x7");
        do_op(1'b1, 1'b0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 1'b0, "mult_neg3x5");
        do_op(1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, "mult_ovf");
        do_op(1'b1, 1'b0, 32'h80000000, 32'd1, 32'h80000000, 1'b0, "mult_min_x1");
        do_op(1'b1, 1'b0, 32'hFFFFFFFA, 32'hFFFFFFF9, 32'h0000002A, 1'b0, "mult_neg_neg");
        do_op(1'b1, 1'b1, 32'd6, 32'd7, 32'h0000002A, 1'b0, "both_strobes");
    endtask

    task automatic test_div();
        do_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, "div_neg7_2");
        do_op(1'b0, 1'b1, 32'd5, 32'd0, 32'h00000000, 1'b1, "div_by_zero");
        do_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "div_min_neg1");
        do_op(1'b0, 1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, "div_100_neg7");
        do_op(1'b0, 1'b1, 32'd3, 32'd7, 32'h00000000, 1'b0, "div_small");
    endtask

    // Busy-time strobe is ignored; reset mid-op aborts without a ready pulse.
    task automatic test_interference();
        int k;
        bit seen;
        @(negedge clock);
        ctrl_MULT = 1'b1;
        data_operandA = 32'd123;
        data_operandB = 32'hFFFFFFFC;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        k = 0;
        do begin
            @(negedge clock);
            k++;
            if (k == 5) begin
                ctrl_DIV = 1'b1;
                data_operandA = 32'd1000;
                data_operandB = 32'd10;
            end else begin
                ctrl_DIV = 1'b0;
            end
        end while (!data_resultRDY && k < 50);
        vectors++;
        if (k !== 34 || data_result !== 32'hFFFFFE14 || data_exception !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_strobe: got k=%0d res=%08h exc=%b, want 34 fffffe14 0",
                     k, data_result, data_exception);
        end
        repeat (3) @(negedge clock);
        vectors++;
        if (busy !== 1'b0 || data_resultRDY !== 1'b0) begin
            miscompares++;
            $display("FAIL no_second_op: got busy=%b rdy=%b, want 0 0", busy, data_resultRDY);
        end

        ctrl_MULT = 1'b1;
        data_operandA = 32'd3;
        data_operandB = 32'd3;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        for (int i = 1; i < 10; i++) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        vectors++;
        if ({data_result, data_exception, data_resultRDY, busy} !== 35'h0) begin
            miscompares++;
            $display("FAIL midop_reset: got res=%08h exc=%b rdy=%b busy=%b, want all 0",
                     data_result, data_exception, data_resultRDY, busy);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (data_resultRDY || busy) seen = 1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL aborted_op_silent: got activity=%b, want 0", seen);
        end
    endtask

    // Strobe in RDY cycle ignored; strobe the cycle after starts a new op.
    task automatic test_back_to_back();
        int k;
        @(negedge clock);
        ctrl_DIV = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!data_resultRDY && k < 50);
        vectors++;
        if (k !== 34 || data_result !== 32'd14) begin
            miscompares++;
            $display("FAIL b2b_first: got k=%0d res=%08h, want 34 0000000e", k, data_result);
        end
        ctrl_DIV = 1'b1;
        data_operandA = 32'd1000;
        data_operandB = 32'd10;
        @(negedge clock);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rdy_strobe_ignored: got busy=%b, want 0", busy);
        end
        ctrl_DIV = 1'b0;
        ctrl_MULT = 1'b1;
        data_operandA = 32'hFFFFFFFA;
        data_operandB = 32'hFFFFFFF9;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        @(negedge clock);
        vectors++;
        if (busy !== 1'b1 || data_result !== 32'd14) begin
            miscompares++;
            $display("FAIL result_held_at_start: got busy=%b res=%08h, want 1 0000000e",
                     busy, data_result);
        end
        k = 1;
        while (!data_resultRDY && k < 50) begin
            @(negedge clock);
            k++;
        end
        vectors++;
        if (k !== 34 || data_result !== 32'd42 || data_exception !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second: got k=%0d res=%08h exc=%b, want 34 0000002a 0",
                     k, data_result, data_exception);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_mult();
        test_div();
        test_interference();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
